// File: rtl/async_fifo_pkg.sv
// Shared constants and pointer-code helpers for both controllers of the async FIFO.
// Gray/binary helpers work on a wide vector so any narrower pointer can be zero-extended into them.
package async_fifo_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 5;
    localparam int PTR_WIDTH   = ADDR_WIDTH + 1;
    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam int SYNC_STAGES = 2;
    localparam int CODE_WIDTH  = 32;

    function automatic logic [CODE_WIDTH-1:0] bin2gray(input logic [CODE_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Leading zeros of a zero-extended code stay zero, so the low bits are exact.
    function automatic logic [CODE_WIDTH-1:0] gray2bin(input logic [CODE_WIDTH-1:0] gray);
        logic [CODE_WIDTH-1:0] bin;
        bin[CODE_WIDTH-1] = gray[CODE_WIDTH-1];
        for (int i = CODE_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
// Cleared asynchronously by rst_n and synchronously by clr.
module ptr_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_reg [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: drives the memory write port, keeps the
// binary/Gray write pointers and derives full, almost-full, overflow and level status.
module fifo_wr_ctrl #(
    parameter int DATA_WIDTH  = async_fifo_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH  = async_fifo_pkg::ADDR_WIDTH,
    parameter int SYNC_STAGES = async_fifo_pkg::SYNC_STAGES
) (
    input  logic                  wclk,
    input  logic                  hw_rst_n,
    input  logic                  sw_rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] afull_value,
    input  logic [ADDR_WIDTH:0]   rptr_gray,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  wdfull,
    output logic                  wr_almost_full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   fifo_write_count,
    output logic [ADDR_WIDTH:0]   wr_level
);

    import async_fifo_pkg::*;

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]      wbin_reg;
    logic [PTR_W-1:0]      wbin_next;
    logic [PTR_W-1:0]      wgray_reg;
    logic [PTR_W-1:0]      wgray_next;
    logic [PTR_W-1:0]      level_reg;
    logic [PTR_W-1:0]      level_next;
    logic [PTR_W-1:0]      rq_gray;
    logic [PTR_W-1:0]      rq_bin;
    logic [PTR_W-1:0]      full_code;
    logic                  full_reg;
    logic                  full_next;
    logic                  afull_reg;
    logic                  afull_next;
    logic                  overflow_reg;
    logic                  overflow_next;
    logic                  accept;
    logic [CODE_WIDTH-1:0] wgray_wide;
    logic [CODE_WIDTH-1:0] rq_bin_wide;
    logic                  unused_code_bits;

    ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk   (wclk),
        .rst_n (hw_rst_n),
        .clr   (sw_rst),
        .d     (rptr_gray),
        .q     (rq_gray)
    );

    // Full when our Gray pointer is one lap ahead of the synchronised read pointer:
    // in Gray code that is the read pointer with its two top bits inverted.
    assign full_code = {~rq_gray[PTR_W-1:PTR_W-2], rq_gray[PTR_W-3:0]};

    always_comb begin
        accept        = write_enable & ~full_reg & ~sw_rst & hw_rst_n;
        wbin_next     = wbin_reg + PTR_W'(accept);
        wgray_wide    = bin2gray(CODE_WIDTH'(wbin_next));
        wgray_next    = wgray_wide[PTR_W-1:0];
        rq_bin_wide   = gray2bin(CODE_WIDTH'(rq_gray));
        rq_bin        = rq_bin_wide[PTR_W-1:0];
        level_next    = wbin_next - rq_bin;
        afull_next    = (level_next >= PTR_W'(afull_value));
        full_next     = (wgray_next == full_code);
        overflow_next = write_enable & full_reg;
    end

    assign unused_code_bits = ^{wgray_wide[CODE_WIDTH-1:PTR_W], rq_bin_wide[CODE_WIDTH-1:PTR_W]};

    always_ff @(posedge wclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            wbin_reg     <= '0;
            wgray_reg    <= '0;
            level_reg    <= '0;
            full_reg     <= 1'b0;
            afull_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (sw_rst) begin
            wbin_reg     <= '0;
            wgray_reg    <= '0;
            level_reg    <= '0;
            full_reg     <= 1'b0;
            afull_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wbin_reg     <= wbin_next;
            wgray_reg    <= wgray_next;
            level_reg    <= level_next;
            full_reg     <= full_next;
            afull_reg    <= afull_next;
            overflow_reg <= overflow_next;
        end
    end

    // The registered write count is by definition the binary pointer itself.
    assign fifo_write_count = wbin_reg;
    assign wptr_gray        = wgray_reg;
    assign wr_level         = level_reg;
    assign wdfull           = full_reg;
    assign wr_almost_full   = afull_reg;
    assign overflow         = overflow_reg;
    assign mem_wen          = accept;
    assign mem_waddr        = wbin_reg[ADDR_WIDTH-1:0];
    assign mem_wdata        = write_data;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: vector table, directed corner sequences and
// randomized traffic against an occupancy model built from accepted-write and read totals.
module tb_fifo_wr_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SS = 2;

    logic          wclk = 1'b0;
    logic          hw_rst_n;
    logic          sw_rst;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic [AW-1:0] afull_value;
    logic [AW:0]   rptr_gray;
    logic [AW:0]   wptr_gray;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          wdfull;
    logic          wr_almost_full;
    logic          overflow;
    logic [AW:0]   fifo_write_count;
    logic [AW:0]   wr_level;

    fifo_wr_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .SYNC_STAGES (SS)
    ) dut (
        .wclk             (wclk),
        .hw_rst_n         (hw_rst_n),
        .sw_rst           (sw_rst),
        .write_enable     (write_enable),
        .write_data       (write_data),
        .afull_value      (afull_value),
        .rptr_gray        (rptr_gray),
        .wptr_gray        (wptr_gray),
        .mem_wen          (mem_wen),
        .mem_waddr        (mem_waddr),
        .mem_wdata        (mem_wdata),
        .wdfull           (wdfull),
        .wr_almost_full   (wr_almost_full),
        .overflow         (overflow),
        .fifo_write_count (fifo_write_count),
        .wr_level         (wr_level)
    );

    always #5 wclk = ~wclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: totals of accepted writes and of reads, plus history of the read total
    int wr_total;
    int rd_now;
    int rd_q[$];
    int lvl_m;
    bit full_m;
    bit afull_m;
    bit ovf_m;
    logic          last_wen;
    logic [AW-1:0] last_waddr;

    typedef struct {
        logic sr;
        logic we;
        int   rd;
        int   afv;
        logic e_wen;
        int   e_addr;
        int   e_lvl;
        logic e_afull;
        int   e_cnt;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [AW:0] to_gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wr_total = 0;
        rd_now   = 0;
        rd_q.delete();
        lvl_m    = 0;
        full_m   = 0;
        afull_m  = 0;
        ovf_m    = 0;
    endtask

    task automatic model_edge();
        int rq;
        bit acc;
        if (sw_rst) begin
            model_reset();
            return;
        end
        acc     = write_enable && !full_m;
        rq      = (rd_q.size() >= SS) ? rd_q[rd_q.size() - SS] : 0;
        ovf_m   = write_enable && full_m;
        wr_total += int'(acc);
        lvl_m   = (((wr_total - rq) % 64) + 64) % 64;
        full_m  = (lvl_m == 32);
        afull_m = (lvl_m >= int'(afull_value));
        rd_q.push_back(rd_now);
    endtask

    task automatic step(input logic we, input logic sr);
        bit exp_wen;
        @(negedge wclk);
        write_enable = we;
        sw_rst       = sr;
        write_data   = $urandom;
        rptr_gray    = to_gray(rd_now);
        #1;
        exp_wen    = we && !full_m && !sr;
        last_wen   = mem_wen;
        last_waddr = mem_waddr;
        chk("mem_wen", mem_wen, exp_wen);
        chk("mem_waddr", mem_waddr, wr_total % 32);
        chk("mem_wdata", mem_wdata, write_data);
        @(posedge wclk);
        model_edge();
        #1;
        chk("wr_level", wr_level, lvl_m);
        chk("wdfull", wdfull, full_m);
        chk("wr_almost_full", wr_almost_full, afull_m);
        chk("overflow", overflow, ovf_m);
        chk("fifo_write_count", fifo_write_count, wr_total % 64);
        chk("wptr_gray", wptr_gray, to_gray(wr_total));
    endtask

    task automatic hard_reset();
        @(negedge wclk);
        hw_rst_n     = 1'b0;
        write_enable = 1'b0;
        sw_rst       = 1'b0;
        rptr_gray    = '0;
        model_reset();
        @(negedge wclk);
        hw_rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wptr_gray"}, wptr_gray, 0);
        chk({tag, "_wdfull"}, wdfull, 0);
        chk({tag, "_afull"}, wr_almost_full, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_count"}, fifo_write_count, 0);
        chk({tag, "_level"}, wr_level, 0);
        chk({tag, "_mem_wen"}, mem_wen, 0);
    endtask

    initial begin
        hw_rst_n     = 1'b0;
        sw_rst       = 1'b0;
        write_enable = 1'b0;
        write_data   = '0;
        afull_value  = '0;
        rptr_gray    = '0;
        last_wen     = 1'b0;
        last_waddr   = '0;
        model_reset();

        vecs[0] = '{1'b0, 1'b1, 0, 3, 1'b1, 0, 1, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b1, 0, 3, 1'b1, 1, 2, 1'b0, 2};
        vecs[2] = '{1'b0, 1'b0, 0, 3, 1'b0, 2, 2, 1'b0, 2};
        vecs[3] = '{1'b0, 1'b1, 0, 3, 1'b1, 2, 3, 1'b1, 3};
        vecs[4] = '{1'b1, 1'b1, 0, 3, 1'b0, 3, 0, 1'b0, 0};
        vecs[5] = '{1'b0, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, 0};
        vecs[6] = '{1'b0, 1'b1, 0, 0, 1'b1, 0, 1, 1'b1, 1};
        vecs[7] = '{1'b0, 1'b0, 1, 0, 1'b0, 1, 1, 1'b1, 1};
        vecs[8] = '{1'b0, 1'b0, 1, 0, 1'b0, 1, 1, 1'b1, 1};
        vecs[9] = '{1'b0, 1'b0, 1, 0, 1'b0, 1, 0, 1'b1, 1};

        // Reset state while hw_rst_n is held low with a write pending
        write_enable = 1'b1;
        #3;
        check_all_zero("por");
        write_enable = 1'b0;
        @(negedge wclk);
        hw_rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            afull_value = vecs[i].afv[AW-1:0];
            rd_now      = vecs[i].rd;
            step(vecs[i].we, vecs[i].sr);
            chk("tbl_wen", last_wen, vecs[i].e_wen);
            chk("tbl_addr", last_waddr, vecs[i].e_addr);
            chk("tbl_level", wr_level, vecs[i].e_lvl);
            chk("tbl_afull", wr_almost_full, vecs[i].e_afull);
            chk("tbl_count", fifo_write_count, vecs[i].e_cnt);
        end

        // Asynchronous reset in the middle of a fill at level 10
        hard_reset();
        afull_value = 5'd31;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk("pre_areset_level", wr_level, 10);
        @(negedge wclk);
        write_enable = 1'b1;
        #2;
        hw_rst_n = 1'b0;
        #1;
        check_all_zero("areset");
        @(posedge wclk);
        #1;
        check_all_zero("areset_hold");
        @(negedge wclk);
        write_enable = 1'b0;
        model_reset();
        hw_rst_n = 1'b1;

        // Fill 32 back-to-back
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0);
            chk("fill_addr", last_waddr, i);
            if (i == 29) chk("fill_afull_30", wr_almost_full, 0);
            if (i == 30) chk("fill_afull_31", wr_almost_full, 1);
        end
        chk("fill_full", wdfull, 1);
        chk("fill_level", wr_level, 32);
        chk("fill_wptr_gray", wptr_gray, 6'b110000);

        // Overflow while full
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            chk("ovf_wen", last_wen, 0);
            chk("ovf_pulse", overflow, 1);
            chk("ovf_level", wr_level, 32);
            chk("ovf_count", fifo_write_count, 32);
        end
        step(1'b0, 1'b0);
        chk("ovf_clear", overflow, 0);

        // Release: read pointer jumps to 4, full drops SS+1 edges later
        rd_now = 4;
        step(1'b0, 1'b0);
        chk("rel_full_e1", wdfull, 1);
        step(1'b0, 1'b0);
        chk("rel_full_e2", wdfull, 1);
        step(1'b0, 1'b0);
        chk("rel_full_e3", wdfull, 0);
        chk("rel_level", wr_level, 28);
        step(1'b1, 1'b0);
        chk("rel_addr", last_waddr, 0);
        chk("rel_wen", last_wen, 1);

        // Wrap-around from pointer 60
        hard_reset();
        afull_value = 5'd31;
        for (int i = 0; i < 60; i++) begin
            rd_now = wr_total;
            step(1'b1, 1'b0);
        end
        rd_now = 60;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("wrap_start_level", wr_level, 0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0);
            chk("wrap_addr", last_waddr, (28 + k) % 32);
            chk("wrap_count", fifo_write_count, (61 + k) % 64);
        end
        chk("wrap_level", wr_level, 8);
        chk("wrap_full", wdfull, 0);

        // Soft reset at level 20 with a write pending
        hard_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        chk("sreset_pre_level", wr_level, 20);
        step(1'b1, 1'b1);
        chk("sreset_wen", last_wen, 0);
        check_all_zero("sreset");
        step(1'b1, 1'b0);
        chk("sreset_next_addr", last_waddr, 0);
        chk("sreset_next_wen", last_wen, 1);

        // Randomized traffic in write-heavy and read-heavy phases
        hard_reset();
        for (int ph = 0; ph < 4; ph++) begin
            int wr_pct;
            int rd_pct;
            wr_pct      = (ph % 2 == 0) ? 85 : 40;
            rd_pct      = (ph % 2 == 0) ? 30 : 80;
            afull_value = AW'($urandom_range(0, 31));
            for (int c = 0; c < 300; c++) begin
                logic we;
                logic sr;
                if (rd_now < wr_total && $urandom_range(0, 99) < rd_pct) rd_now++;
                we = ($urandom_range(0, 99) < wr_pct);
                sr = ($urandom_range(0, 249) == 0);
                step(we, sr);
                if (sr) rd_now = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
